// File: rtl/interface_hcsr04_uc.sv
// rtl/interface_hcsr04_uc.sv - HC-SR04 measurement control unit
// Sequences clear, trigger and echo-gated counting for one distance measurement.
module interface_hcsr04_uc #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
  parameter int unsigned TW             = 21
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       medir,
  input  logic       echo,
  input  logic       fim_cm,
  output logic       trigger,
  output logic       zera_tick,
  output logic       zera_bcd,
  output logic       conta_tick,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL     = 3'd0,
    PREPARA     = 3'd1,
    TRIGGER     = 3'd2,
    ESPERA_ECHO = 3'd3,
    MEDIDA      = 3'd4,
    FIM         = 3'd5,
    ERRO        = 3'd6
  } state_t;

  localparam logic [TW-1:0] TRIG_LAST    = TW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ONE          = TW'(1);

  state_t        state, state_next;
  logic [1:0]    echo_sync;
  logic          echo_s;
  logic [TW-1:0] cnt, cnt_next, cnt_sat;

  assign echo_s    = echo_sync[1];
  assign db_estado = {1'b0, state};
  // Saturating at the timeout limit keeps the equality compare reachable and prevents wrap.
  assign cnt_sat   = (cnt == TIMEOUT_LAST) ? cnt : cnt + ONE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INICIAL;
      cnt       <= '0;
      echo_sync <= 2'b00;
      trigger   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      echo_sync <= {echo_sync[0], echo};
      trigger   <= (state_next == TRIGGER);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    zera_tick  = 1'b0;
    zera_bcd   = 1'b0;
    conta_tick = 1'b0;
    pronto     = 1'b0;
    erro       = 1'b0;
    case (state)
      INICIAL: begin
        if (medir) state_next = PREPARA;
      end
      PREPARA: begin
        zera_tick  = 1'b1;
        zera_bcd   = 1'b1;
        cnt_next   = '0;
        state_next = TRIGGER;
      end
      TRIGGER: begin
        if (cnt == TRIG_LAST) begin
          cnt_next   = '0;
          state_next = ESPERA_ECHO;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      ESPERA_ECHO: begin
        cnt_next = cnt_sat;
        // Decide on the first sync stage so MEDIDA begins in the first cycle echo_s is high,
        // giving exactly one conta_tick per echo-high clock.
        if (echo_sync[0])              state_next = MEDIDA;
        else if (cnt == TIMEOUT_LAST)  state_next = ERRO;
      end
      MEDIDA: begin
        cnt_next   = cnt_sat;
        conta_tick = echo_s;
        if (fim_cm)                    state_next = ERRO;
        else if (cnt == TIMEOUT_LAST)  state_next = ERRO;
        else if (!echo_s)              state_next = FIM;
      end
      FIM: begin
        pronto     = 1'b1;
        state_next = INICIAL;
      end
      ERRO: begin
        erro       = 1'b1;
        state_next = INICIAL;
      end
      default: state_next = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// tb/tb_interface_hcsr04_uc.sv - bench for interface_hcsr04_uc
// Table vectors, hand sequences and random measurements against a timing model.
module tb_interface_hcsr04_uc;

  localparam int E = 7;  // cycle of ESPERA_ECHO entry, counted from the medir cycle

  logic       clock = 1'b0;
  logic       reset_n, medir, echo, fim_cm;
  logic       trigger, zera_tick, zera_bcd, conta_tick, pronto, erro;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  interface_hcsr04_uc #(.TRIG_CYCLES(5), .TIMEOUT_CYCLES(100), .TW(21)) dut (
    .clock(clock), .reset_n(reset_n), .medir(medir), .echo(echo), .fim_cm(fim_cm),
    .trigger(trigger), .zera_tick(zera_tick), .zera_bcd(zera_bcd), .conta_tick(conta_tick),
    .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int d;
    int h;
    int fim_rel;
    bit hold;
    int exp_ticks;
    bit exp_pr;
    int exp_out;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Echo-high time H gives H ticks; echo_s lags the pin by 2; counter starts at 0 on
  // ESPERA_ECHO entry and limit 99 aborts; fim_cm aborts from MEDIDA with that cycle's tick.
  task automatic model(input int d, input int h, input int fim_rel,
                       output int ticks, output bit pr, output int out_rel);
    int r;
    bit es;
    ticks = 0; pr = 1'b0; out_rel = 100;
    if (h > 0) begin
      r = d + 2;
      for (int j = r; j <= 100; j++) begin
        es = (j < r + h);
        if (j == fim_rel || j >= 99) begin
          ticks += int'(es); out_rel = j + 1; break;
        end
        if (!es) begin
          pr = 1'b1; out_rel = j + 1; break;
        end
        ticks++;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_meas(input int d, input int h, input int fim_rel, input bit hold,
                          input int exp_ticks, input bit exp_pr, input int exp_out,
                          input string tag);
    int trig_cnt = 0, trig_first = -1, ticks = 0, pr_cnt = 0, er_cnt = 0;
    int out_cyc = -1, zmis = 0, est0 = -1;
    int zq[$];
    for (int cyc = 0; cyc < 125; cyc++) begin
      int rel;
      @(posedge clock); #1;
      rel    = cyc - E;
      medir  = (cyc == 0) || hold;
      echo   = (h > 0) && (rel >= d) && (rel < d + h);
      fim_cm = (fim_rel >= 0) && (rel == fim_rel);
      @(negedge clock);
      if (cyc == 0) est0 = int'(db_estado);
      if (cyc < E + exp_out) begin
        if (trigger) begin
          trig_cnt++;
          if (trig_first < 0) trig_first = cyc;
        end
        if (conta_tick) ticks++;
      end
      if (zera_tick) zq.push_back(cyc);
      if (zera_tick != zera_bcd) zmis++;
      if (pronto) begin
        pr_cnt++;
        if (out_cyc < 0) out_cyc = cyc - E;
      end
      if (erro) begin
        er_cnt++;
        if (out_cyc < 0) out_cyc = cyc - E;
      end
    end
    medir = 1'b0; echo = 1'b0; fim_cm = 1'b0;
    check({tag, "_state0"}, est0, 0);
    check({tag, "_trig_len"}, trig_cnt, 5);
    check({tag, "_trig_first"}, trig_first, 2);
    check({tag, "_ticks"}, ticks, exp_ticks);
    check({tag, "_pronto_cnt"}, pr_cnt, int'(exp_pr));
    check({tag, "_erro_cnt"}, er_cnt, int'(!exp_pr));
    check({tag, "_out_cycle"}, out_cyc, exp_out);
    check({tag, "_zera_match"}, zmis, 0);
    check({tag, "_zera_n"}, zq.size(), hold ? 2 : 1);
    check({tag, "_zera_at"}, (zq.size() > 0) ? zq[0] : -1, 1);
    if (hold) begin
      check({tag, "_zera2_at"}, (zq.size() > 1) ? zq[1] : -1, E + exp_out + 2);
      do_reset();
    end
    @(negedge clock);
    check({tag, "_idle"}, int'(db_estado), 0);
  endtask

  initial begin
    vec_t vecs[9];
    int   mt, mo;
    bit   mp;

    vecs[0] = '{10, 40,  -1, 1'b0, 40, 1'b1, 53};   // nominal echo
    vecs[1] = '{ 0,  0,  -1, 1'b0,  0, 1'b0, 100};  // echo never rises
    vecs[2] = '{20, 200, -1, 1'b0, 78, 1'b0, 100};  // echo stuck high
    vecs[3] = '{ 5, 50,  12, 1'b0,  6, 1'b0, 13};   // fim_cm mid-MEDIDA
    vecs[4] = '{ 3, 10,  -1, 1'b1, 10, 1'b1, 16};   // medir held: back-to-back
    vecs[5] = '{ 0,  1,  -1, 1'b0,  1, 1'b1, 4};    // one-clock echo
    vecs[6] = '{10, 86,  -1, 1'b0, 86, 1'b1, 99};   // falls just before limit
    vecs[7] = '{10, 87,  -1, 1'b0, 87, 1'b0, 100};  // limit wins over fall
    vecs[8] = '{ 5, 50,   7, 1'b0,  1, 1'b0, 8};    // fim_cm on first MEDIDA cycle

    reset_n = 1'b0; medir = 1'b0; echo = 1'b0; fim_cm = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_trigger", int'(trigger), 0);
    check("rst_zera_tick", int'(zera_tick), 0);
    check("rst_zera_bcd", int'(zera_bcd), 0);
    check("rst_conta_tick", int'(conta_tick), 0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_erro", int'(erro), 0);
    check("rst_state", int'(db_estado), 0);
    reset_n = 1'b1;

    // Async reset in the middle of the trigger pulse
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clock); #1;
      medir = (cyc == 0);
      @(negedge clock);
    end
    check("midtrig_trigger", int'(trigger), 1);
    check("midtrig_state", int'(db_estado), 2);
    #2 reset_n = 1'b0;
    #1;
    check("async_trigger", int'(trigger), 0);
    check("async_state", int'(db_estado), 0);
    check("async_zera", int'(zera_tick | zera_bcd | conta_tick), 0);
    check("async_flags", int'(pronto | erro), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_meas(vecs[i].d, vecs[i].h, vecs[i].fim_rel, vecs[i].hold,
               vecs[i].exp_ticks, vecs[i].exp_pr, vecs[i].exp_out, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      int d, h, f;
      d = int'($urandom_range(0, 85));
      h = int'($urandom_range(1, 110));
      f = ($urandom_range(0, 3) == 0) ? d + 2 + int'($urandom_range(0, 15)) : -1;
      model(d, h, f, mt, mp, mo);
      run_meas(d, h, f, 1'b0, mt, mp, mo, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
